// File: rtl/simple_adder_8bit.sv
// Registered ripple-carry adder: sum = a + b + cin with carry-out, signed
// overflow and zero flags, one cycle of latency.
module simple_adder_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_p0;
    logic             cout_p0;
    logic             ovf_p0;
    logic             zero_p0;
    logic             carry;
    logic             carry_msb;

    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic             ovf_p1;
    logic             zero_p1;
    logic             vld_p1;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | ((x ^ y) & c);
    endfunction

    // Stage p0: combinational ripple chain; carry_msb keeps the carry into
    // the MSB so overflow can be formed from the last two carries.
    always_comb begin
        sum_p0    = '0;
        carry     = cin;
        carry_msb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_p0[i] = fa_sum(a[i], b[i], carry);
            carry_msb = carry;
            carry     = fa_carry(a[i], b[i], carry);
        end
        cout_p0 = carry;
        ovf_p0  = carry ^ carry_msb;
        zero_p0 = (sum_p0 == '0);
    end

    // Stage p1: result registers; data holds when no valid input arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
            zero_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1  <= sum_p0;
                cout_p1 <= cout_p0;
                ovf_p1  <= ovf_p0;
                zero_p1 <= zero_p0;
            end
        end
    end

    assign sum       = sum_p1;
    assign cout      = cout_p1;
    assign overflow  = ovf_p1;
    assign zero      = zero_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_simple_adder_8bit.sv
// Directed and random checks for simple_adder_8bit.
module tb_simple_adder_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;
    logic       zero;
    logic       out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    simple_adder_8bit #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic add_chk(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                           input logic ic, input logic [7:0] e_sum, input logic e_cout,
                           input logic e_ovf, input logic e_zero);
        @(negedge clk);
        a = ia; b = ib; cin = ic; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".sum"}, 32'(sum), 32'(e_sum));
        check({tag, ".cout"}, 32'(cout), 32'(e_cout));
        check({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
        check({tag, ".zero"}, 32'(zero), 32'(e_zero));
        check({tag, ".vld"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.sum", 32'(sum), 32'h00);
        check("rst.cout", 32'(cout), 32'd0);
        check("rst.vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle.sum", 32'(sum), 32'h00);
        check("idle.vld", 32'(out_valid), 32'd0);

        add_chk("add01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
        add_chk("add03_03", 8'h03, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0);
        add_chk("wrapFF_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        add_chk("wrapFF_FF", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        add_chk("wrapFF_FF_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        add_chk("zero00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        add_chk("cin00", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        add_chk("cin01", 8'h01, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        add_chk("cin03", 8'h03, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
        add_chk("cin7F", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        add_chk("cinFF", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        add_chk("ovf80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        add_chk("ovf40_40", 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        add_chk("ovfFF_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Valid gating: result must hold while in_valid is low.
        add_chk("gate10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'h55; b = 8'h55; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("gate.sum", 32'(sum), 32'h30);
        check("gate.vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        a = 'x; b = 'x; cin = 1'bx;
        @(posedge clk);
        #1;
        check("gate_x.sum", 32'(sum), 32'h30);
        check("gate_x.zero", 32'(zero), 32'd0);
        cin = 1'b0;

        // Random back-to-back valid inputs.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            logic [8:0] full;
            logic       eovf;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            eovf = (ra[7] == rb[7]) && (full[7] != ra[7]);
            add_chk("rand", ra, rb, rc, full[7:0], full[8], eovf, full[7:0] == 8'h00);
        end

        // Asynchronous reset mid-run clears outputs without a clock edge.
        add_chk("pre_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.sum", 32'(sum), 32'h00);
        check("arst.cout", 32'(cout), 32'd0);
        check("arst.vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.vld", 32'(out_valid), 32'd0);
        add_chk("post_rst", 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
